mem_port_arbiter: RTL



---
 rtl/mem_port_arbiter_if.sv | 50 +++++
 rtl/mem_port_arbiter.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
//   Bundles the two upstream submit/ack ports (fetch I, data D) and the shared
//   downstream memory bus into one interface.
//   Modports:
//     master - the arbiter's view: takes submits and bus acks, drives upstream
//              acks/data and the registered bus request.
//     slave  - the environment's view (core fetch/mem stages plus memory).
//   Signals:
//     i_i_addr/i_i_submit              fetch request (address valid with the pulse)
//     o_i_data/o_i_ack                 fetch completion and read data
//     i_d_addr/i_d_wdata/i_d_we/i_d_submit  data request (valid with the pulse)
//     o_d_data/o_d_ack                 data completion and read data
//     o_bus_cyc/o_bus_addr/o_bus_wdata/o_bus_we/o_bus_ispace  bus request
//     i_bus_ack/i_bus_rdata            bus completion pulse and read data
interface mem_port_arbiter_if #(
  parameter int RW     = 16,
  parameter int I_SIZE = 32
) ();
  logic [RW-1:0]     i_i_addr;
  logic              i_i_submit;
  logic [I_SIZE-1:0] o_i_data;
  logic              o_i_ack;
  logic [RW-1:0]     i_d_addr;
  logic [RW-1:0]     i_d_wdata;
  logic              i_d_we;
  logic              i_d_submit;
  logic [RW-1:0]     o_d_data;
  logic              o_d_ack;
  logic              o_bus_cyc;
  logic [RW-1:0]     o_bus_addr;
  logic [RW-1:0]     o_bus_wdata;
  logic              o_bus_we;
  logic              o_bus_ispace;
  logic              i_bus_ack;
  logic [I_SIZE-1:0] i_bus_rdata;

  modport master (
    input  i_i_addr, i_i_submit, i_d_addr, i_d_wdata, i_d_we, i_d_submit,
    input  i_bus_ack, i_bus_rdata,
    output o_i_data, o_i_ack, o_d_data, o_d_ack,
    output o_bus_cyc, o_bus_addr, o_bus_wdata, o_bus_we, o_bus_ispace
  );

  modport slave (
    output i_i_addr, i_i_submit, i_d_addr, i_d_wdata, i_d_we, i_d_submit,
    output i_bus_ack, i_bus_rdata,
    input  o_i_data, o_i_ack, o_d_data, o_d_ack,
    input  o_bus_cyc, o_bus_addr, o_bus_wdata, o_bus_we, o_bus_ispace
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one memory bus between the instruction-fetch port (I) and the
//   data port (D). Each port has a one-entry pending slot (latest submit
//   wins). One transaction runs at a time; D has priority, except that after
//   STARVE_LIMIT consecutive D grants made while I was waiting, I wins.
//   Ports:
//     i_clk  clock
//     i_rst  synchronous active-high reset
//     bus    mem_port_arbiter_if.master (upstream ports + downstream bus)
module mem_port_arbiter #(
  parameter int RW           = 16,
  parameter int I_SIZE       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input logic                i_clk,
  input logic                i_rst,
  mem_port_arbiter_if.master bus
);

  localparam int            SW         = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_e;

  state_e          state_q, state_d;
  logic            i_vld_q, i_vld_d;
  logic [RW-1:0]   i_addr_q, i_addr_d;
  logic            d_vld_q, d_vld_d;
  logic [RW-1:0]   d_addr_q, d_addr_d;
  logic [RW-1:0]   d_wdata_q, d_wdata_d;
  logic            d_we_q, d_we_d;
  logic [SW-1:0]   starve_q, starve_d;
  logic            bus_cyc_q, bus_cyc_d;
  logic [RW-1:0]   bus_addr_q, bus_addr_d;
  logic [RW-1:0]   bus_wdata_q, bus_wdata_d;
  logic            bus_we_q, bus_we_d;
  logic            bus_ispace_q, bus_ispace_d;
  logic            arb_en;

  // A grant decision is made whenever the bus is free at this edge: idle, or
  // the current transaction completes now. A bus ack while idle is harmless
  // here because it does not change what an idle arbitration would do.
  assign arb_en = (state_q == IDLE) || bus.i_bus_ack;

  // Upstream acks are combinational from the bus ack; reset suppresses them.
  assign bus.o_i_ack  = (state_q == BUSY_I) && bus.i_bus_ack && !i_rst;
  assign bus.o_d_ack  = (state_q == BUSY_D) && bus.i_bus_ack && !i_rst;
  assign bus.o_i_data = bus.i_bus_rdata;
  assign bus.o_d_data = bus.i_bus_rdata[RW-1:0];

  assign bus.o_bus_cyc    = bus_cyc_q;
  assign bus.o_bus_addr   = bus_addr_q;
  assign bus.o_bus_wdata  = bus_wdata_q;
  assign bus.o_bus_we     = bus_we_q;
  assign bus.o_bus_ispace = bus_ispace_q;

  always_comb begin
    // NOTE: every signal gets a default first, so no path can infer a latch.
    state_d      = state_q;
    i_vld_d      = i_vld_q;
    i_addr_d     = i_addr_q;
    d_vld_d      = d_vld_q;
    d_addr_d     = d_addr_q;
    d_wdata_d    = d_wdata_q;
    d_we_d       = d_we_q;
    starve_d     = starve_q;
    bus_cyc_d    = bus_cyc_q;
    bus_addr_d   = bus_addr_q;
    bus_wdata_d  = bus_wdata_q;
    bus_we_d     = bus_we_q;
    bus_ispace_d = bus_ispace_q;

    // Same-cycle submits join the candidates and overwrite an unissued slot.
    if (bus.i_i_submit) begin
      i_vld_d  = 1'b1;
      i_addr_d = bus.i_i_addr;
    end
    if (bus.i_d_submit) begin
      d_vld_d   = 1'b1;
      d_addr_d  = bus.i_d_addr;
      d_wdata_d = bus.i_d_wdata;
      d_we_d    = bus.i_d_we;
    end

    if (arb_en) begin
      if (i_vld_d && (!d_vld_d || starve_q == STARVE_MAX)) begin
        state_d      = BUSY_I;
        i_vld_d      = 1'b0;
        starve_d     = '0;
        bus_cyc_d    = 1'b1;
        bus_addr_d   = i_addr_d;
        bus_wdata_d  = '0;
        bus_we_d     = 1'b0;
        bus_ispace_d = 1'b1;
      end else if (d_vld_d) begin
        state_d      = BUSY_D;
        d_vld_d      = 1'b0;
        // Count only D grants that make a waiting fetch wait longer.
        if (!i_vld_d)                   starve_d = '0;
        else if (starve_q != STARVE_MAX) starve_d = starve_q + SW'(1);
        bus_cyc_d    = 1'b1;
        bus_addr_d   = d_addr_d;
        bus_wdata_d  = d_wdata_d;
        bus_we_d     = d_we_d;
        bus_ispace_d = 1'b0;
      end else begin
        state_d   = IDLE;
        bus_cyc_d = 1'b0;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples its pre-edge inputs regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= IDLE;
      i_vld_q      <= 1'b0;
      i_addr_q     <= '0;
      d_vld_q      <= 1'b0;
      d_addr_q     <= '0;
      d_wdata_q    <= '0;
      d_we_q       <= 1'b0;
      starve_q     <= '0;
      bus_cyc_q    <= 1'b0;
      bus_addr_q   <= '0;
      bus_wdata_q  <= '0;
      bus_we_q     <= 1'b0;
      bus_ispace_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      i_vld_q      <= i_vld_d;
      i_addr_q     <= i_addr_d;
      d_vld_q      <= d_vld_d;
      d_addr_q     <= d_addr_d;
      d_wdata_q    <= d_wdata_d;
      d_we_q       <= d_we_d;
      starve_q     <= starve_d;
      bus_cyc_q    <= bus_cyc_d;
      bus_addr_q   <= bus_addr_d;
      bus_wdata_q  <= bus_wdata_d;
      bus_we_q     <= bus_we_d;
      bus_ispace_q <= bus_ispace_d;
    end
  end

endmodule
